// File: rtl/systolic_input_skewer.sv
// Input skewer for the weight-stationary systolic array: lane i of each accepted row
// is delayed i extra cycles, then the pipeline is drained with zeros before done.
module systolic_input_skewer #(
   parameter int DATAWIDTH = 8,
   parameter int N_SIZE    = 32,
   parameter int NUM_ROWS  = 512,
   parameter int BUS_WIDTH = N_SIZE * DATAWIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            in_valid,
   input  logic [BUS_WIDTH-1:0]            in_data,
   output logic                            in_ready,
   output logic [BUS_WIDTH-1:0]            out_data,
   output logic [N_SIZE-1:0]               out_lane_valid,
   output logic                            out_valid,
   output logic [$clog2(NUM_ROWS+1)-1:0]   row_cnt,
   output logic                            busy,
   output logic                            done
);

   localparam int CW  = $clog2(NUM_ROWS + 1);
   localparam int DCW = $clog2(N_SIZE + 1);

   localparam logic [CW-1:0]  ROW_MAX    = CW'(NUM_ROWS);
   localparam logic [CW-1:0]  ROW_LAST   = CW'(NUM_ROWS - 1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(N_SIZE - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  row_cnt_q, row_cnt_d;
   logic [DCW-1:0] drain_q, drain_d;
   logic           accept;

   assign accept    = in_valid && (state_q == S_STREAM);
   assign in_ready  = (state_q == S_STREAM);
   assign busy      = (state_q == S_STREAM) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);
   assign row_cnt   = row_cnt_q;
   assign out_valid = |out_lane_valid;

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      drain_d   = drain_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               row_cnt_d = '0;
               state_d   = S_STREAM;
            end
         end
         S_STREAM: begin
            if (accept) begin
               if (row_cnt_q < ROW_MAX) row_cnt_d = row_cnt_q + CW'(1);
               if (row_cnt_q == ROW_LAST) begin
                  drain_d = '0;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_LAST) state_d = S_DONE;
            else                       drain_d = drain_q + DCW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         row_cnt_q <= '0;
         drain_q   <= '0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         drain_q   <= drain_d;
      end
   end

   // Lane i is i+1 registers deep; non-accepted cycles inject a zero bubble so
   // stalls stay aligned across lanes and the pipeline drains with zeros.
   for (genvar i = 0; i < N_SIZE; i++) begin : g_lane
      logic [DATAWIDTH-1:0] dat_q [0:i];
      logic [i:0]           vld_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k <= i; k++) dat_q[k] <= '0;
            vld_q <= '0;
         end else begin
            dat_q[0] <= accept ? in_data[i*DATAWIDTH +: DATAWIDTH] : '0;
            vld_q[0] <= accept;
            for (int k = 1; k <= i; k++) begin
               dat_q[k] <= dat_q[k-1];
               vld_q[k] <= vld_q[k-1];
            end
         end
      end

      assign out_data[i*DATAWIDTH +: DATAWIDTH] = dat_q[i];
      assign out_lane_valid[i]                  = vld_q[i];
   end

endmodule

// File: doc/systolic_input_skewer.md
Name: systolic_input_skewer

Overview:
Upstream feeder for the weight-stationary systolic array. Accepts one activation row per beat, N_SIZE elements packed on a BUS_WIDTH bus, from the input buffer read path. Re-times each row into the diagonal wavefront the array requires: lane i is delayed by i cycles relative to lane 0. After the last row of a tile it drains the skew pipeline with zeros, then signals completion so the array controller can close out the tile.

Parameters:
DATAWIDTH, 8, bits per activation element
N_SIZE, 32, array dimension / number of lanes
NUM_ROWS, 512, rows (beats) per tile
BUS_WIDTH, 256, N_SIZE*DATAWIDTH; element i = bits [i*DATAWIDTH +: DATAWIDTH]

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse that begins a tile; honoured only in IDLE
in_valid  input  1  in_data holds a valid row
in_data  input  BUS_WIDTH  activation row, lane-packed
in_ready  output  1  block accepts a row this cycle
out_data  output  BUS_WIDTH  skewed lanes to array row inputs; a lane whose valid is 0 carries 0
out_lane_valid  output  N_SIZE  per-lane valid qualifying out_data
out_valid  output  1  OR of out_lane_valid
row_cnt  output  $clog2(NUM_ROWS+1)  rows accepted in the current tile
busy  output  1  high in STREAM and DRAIN
done  output  1  one-cycle pulse at tile completion

Behaviour:
- Reset (any time, including mid-tile) forces state IDLE and clears all skew registers, out_data, out_lane_valid, row_cnt and the drain counter. Once rst deasserts, the block waits for a fresh start.
- States:
  - IDLE: in_ready=0, busy=0. On start: row_cnt clears to 0 and the state moves to STREAM.
  - STREAM: in_ready=1, busy=1. A beat is accepted when in_valid && in_ready at the clock edge; each accepted beat increments row_cnt. The edge that accepts beat NUM_ROWS moves the state to DRAIN.
  - DRAIN: in_ready=0, busy=1. Runs for exactly N_SIZE cycles, counted by a drain counter, then moves to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, in_ready=0, then returns to IDLE.
- in_ready, busy and done decode from the state register only (Moore). in_ready never depends combinationally on in_valid.
- Skew pipeline advances every cycle, in every state:
  - Lane i is a chain of i+1 registers.
  - Lane i's stage 0 loads element i of in_data with valid=1 on an accepted beat. Otherwise it loads 0 with valid=0, so stalls become aligned bubbles across all lanes.
  - For a beat accepted at edge E, lane i presents that element on out_data during the cycle after edge E+i. Latency is 1 cycle for lane 0 and N_SIZE cycles for lane N_SIZE-1.
- The DRAIN length of N_SIZE cycles guarantees all lane valids are 0 by the cycle done is high.
- start outside IDLE is ignored. in_valid outside STREAM is ignored: no acceptance, no row_cnt change.
- row_cnt saturates at NUM_ROWS and holds that value through DRAIN and DONE. It clears only on start or reset.
- Pure data movement: no arithmetic on elements, no sign handling.

Test Plan:
All scenarios use N_SIZE=4, DATAWIDTH=8, NUM_ROWS=4.
- Reset mid-STREAM: after 2 beats, pulse rst -> next cycle out_lane_valid=0000, out_data=0, row_cnt=0, state IDLE, in_ready=0. A later in_valid without start is not accepted.
- Back-to-back tile: start, then 4 beats with in_valid=1 where row r element i = 8'h(r*16+i) -> cycle after edge E0 shows lane0=00. Lane3 shows 03 three cycles later. The last valid element (33 on lane3) appears 4 cycles after acceptance of row 3. done pulses once, exactly N_SIZE cycles after DRAIN entry; row_cnt=4.
- Stall bubbles: in_valid pattern 1,0,1,1,1 in STREAM -> every lane shows the same single invalid gap, offset by lane index, with out_data=0 in the gap. Exactly 4 beats are accepted.
- Start while busy: second start pulse during DRAIN -> no effect; done pulses once and row_cnt stays 4.
- Idle inputs: in_valid=1 with data AA.. in IDLE and DONE -> in_ready=0, out_lane_valid stays 0000, row_cnt unchanged.
- Drain completeness: after the final beat, hold in_valid=1 -> no further acceptance, out_valid=0 when done=1, busy=0 in the done cycle.
